// File: rtl/fpmul_pkg.sv
// Shared types and encodings for the fpmul control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional ROUND state selected by FPMUL_CU_ROUND_EN.
package fpmul_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_EXP_ADD,
    S_EXP_BIAS,
    S_WAIT,
    S_CHECK,
    S_NORM,
    S_ROUND,
    S_EXC,
    S_PACK,
    S_DONE
  } state_t;

  // Exponent register source select
  localparam logic [1:0] EP_SEL_SUM  = 2'b00;  // EA + EB
  localparam logic [1:0] EP_SEL_BIAS = 2'b10;  // EP - 127
  localparam logic [1:0] EP_SEL_INC  = 2'b01;  // EP + 1

  // High-mantissa source select, bit 0 has highest priority in the datapath
  localparam logic [2:0] MPH_SEL_MP  = 3'b000;  // MP[47:24]
  localparam logic [2:0] MPH_SEL_SHL = 3'b001;  // shift left with MPL[23]
  localparam logic [2:0] MPH_SEL_INC = 3'b010;  // MPH + 1
  localparam logic [2:0] MPH_SEL_HID = 3'b100;  // 0x800000 after round carry-out

  // GO-to-DONE latency in cycles, with the minimum operand-flag depth
`ifdef FPMUL_CU_ROUND_EN
  localparam int LAT_NORMAL = 7;
`else
  localparam int LAT_NORMAL = 6;
`endif
  localparam int LAT_SPECIAL = 4;

endpackage

// File: rtl/fpmul_cu.sv
// Sequencer for the fpmul_dp datapath: operand capture through packed product.
// Latency: DONE LAT_NORMAL (normal) / LAT_SPECIAL (NaN/Inf/Zero) cycles after GO.
// Backpressure: none; GO is only accepted in IDLE, ignored while BUSY. Macro FPMUL_CU_ROUND_EN adds ROUND.
module fpmul_cu
  import fpmul_pkg::*;
#(
  parameter int BIAS_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       GO,
  input  logic       Op_NaN,
  input  logic       Op_Inf,
  input  logic       Op_Zero,
  input  logic       MPH23,
  input  logic       Round,
  input  logic       Carry,
  input  logic       UFlow,
  input  logic       OFlow,
  output logic       SA_LD,
  output logic       SB_LD,
  output logic       EA_LD,
  output logic       EB_LD,
  output logic       MA_LD,
  output logic       MB_LD,
  output logic       SP_LD,
  output logic       EP_LD,
  output logic       EP_RST,
  output logic       EP_SET,
  output logic [1:0] EP_SEL,
  output logic       MPH_LD,
  output logic       MPH_RST,
  output logic       MPH_SET,
  output logic [2:0] MPH_SEL,
  output logic       MPL_LD,
  output logic       MPL_SEL,
  output logic       UF_RST,
  output logic       UF_LD,
  output logic       OF_RST,
  output logic       OF_LD,
  output logic       P_RST,
  output logic       P_LD,
  output logic       BUSY,
  output logic       DONE
);

  // Extra WAIT cycles beyond the two the FSM already spends before CHECK
  localparam int CW = $clog2(BIAS_CYC);
  localparam logic [CW-1:0] WAIT_INIT = CW'((BIAS_CYC > 2) ? (BIAS_CYC - 3) : 0);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

`ifndef FPMUL_CU_ROUND_EN
  // Rounding status is only consumed when the ROUND state is built
  logic unused_round_status;
  assign unused_round_status = Round ^ Carry;
`endif

  // State and wait-counter registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and strobe decode; statuses are looked at only in the state that uses them
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    SA_LD   = 1'b0;  SB_LD   = 1'b0;  EA_LD   = 1'b0;  EB_LD = 1'b0;
    MA_LD   = 1'b0;  MB_LD   = 1'b0;  SP_LD   = 1'b0;
    EP_LD   = 1'b0;  EP_RST  = 1'b0;  EP_SET  = 1'b0;  EP_SEL = EP_SEL_SUM;
    MPH_LD  = 1'b0;  MPH_RST = 1'b0;  MPH_SET = 1'b0;  MPH_SEL = MPH_SEL_MP;
    MPL_LD  = 1'b0;  MPL_SEL = 1'b0;
    UF_RST  = 1'b0;  UF_LD   = 1'b0;  OF_RST  = 1'b0;  OF_LD = 1'b0;
    P_RST   = 1'b0;  P_LD    = 1'b0;  DONE    = 1'b0;
    case (state)
      S_IDLE: begin
        if (GO) begin
          SA_LD = 1'b1; SB_LD = 1'b1; EA_LD = 1'b1;
          EB_LD = 1'b1; MA_LD = 1'b1; MB_LD = 1'b1;
          UF_RST = 1'b1; OF_RST = 1'b1;
          state_nxt = S_EXP_ADD;
        end
      end
      S_EXP_ADD: begin
        SP_LD = 1'b1;
        EP_LD = 1'b1; EP_SEL = EP_SEL_SUM;
        state_nxt = S_EXP_BIAS;
      end
      S_EXP_BIAS: begin
        EP_LD  = 1'b1; EP_SEL  = EP_SEL_BIAS;
        MPH_LD = 1'b1; MPH_SEL = MPH_SEL_MP;
        MPL_LD = 1'b1; MPL_SEL = 1'b0;
        if (BIAS_CYC > 2) begin
          wait_cnt_nxt = WAIT_INIT;
          state_nxt    = S_WAIT;
        end else begin
          state_nxt = S_CHECK;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) state_nxt = S_CHECK;
        else                wait_cnt_nxt = wait_cnt - 1'b1;
      end
      S_CHECK: begin
        if (Op_NaN) begin
          EP_SET = 1'b1; MPH_SET = 1'b1; state_nxt = S_PACK;
        end else if (Op_Inf) begin
          EP_SET = 1'b1; MPH_RST = 1'b1; state_nxt = S_PACK;
        end else if (Op_Zero) begin
          EP_RST = 1'b1; MPH_RST = 1'b1; state_nxt = S_PACK;
        end else begin
          state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        if (MPH23) begin
          EP_LD = 1'b1; EP_SEL = EP_SEL_INC;
        end else begin
          MPH_LD = 1'b1; MPH_SEL = MPH_SEL_SHL;
          MPL_LD = 1'b1; MPL_SEL = 1'b1;
        end
`ifdef FPMUL_CU_ROUND_EN
        state_nxt = S_ROUND;
`else
        state_nxt = S_EXC;
`endif
      end
`ifdef FPMUL_CU_ROUND_EN
      S_ROUND: begin
        if (Round && Carry) begin
          MPH_LD = 1'b1; MPH_SEL = MPH_SEL_HID;
          EP_LD  = 1'b1; EP_SEL  = EP_SEL_INC;
        end else if (Round) begin
          MPH_LD = 1'b1; MPH_SEL = MPH_SEL_INC;
        end
        state_nxt = S_EXC;
      end
`endif
      S_EXC: begin
        if (UFlow) begin
          UF_LD = 1'b1; EP_RST = 1'b1; MPH_RST = 1'b1;
        end else if (OFlow) begin
          OF_LD = 1'b1; EP_SET = 1'b1; MPH_RST = 1'b1;
        end
        state_nxt = S_PACK;
      end
      S_PACK: begin
        P_LD = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    BUSY = (state != S_IDLE);
  end

endmodule
